pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Top-level Pong game sequencer. Owns scores and the round state machine.
//  Drives the Ready/Start/Reset strobes to both paddle controllers and the launch strobe to the ball block.
//  Consumes miss pulses from the ball block and a once-per-frame tick from the VGA sync block.
//  Sits between the button synchronisers and the paddle/ball datapath.
// PARAMETERS
//  WIN_SCORE     7   points needed to win; range 1..15
//  SERVE_FRAMES  60  frame ticks spent in READY before a serve; must be >=1
//  POINT_FRAMES  30  frame ticks spent in POINT after a score; must be >=1
// PORTS
//  i_Clk           in   1  system/pixel clock
//  i_Reset_n       in   1  synchronous reset, active-low
//  i_Start         in   1  start button, synchronised level; a rising edge is detected internally
//  i_Frame_Tick    in   1  one-cycle pulse per video frame
//  i_Miss_P1       in   1  one-cycle pulse: ball passed P1 (left) paddle
//  i_Miss_P2       in   1  one-cycle pulse: ball passed P2 (right) paddle
//  o_Paddle_Ready  out  1  one-cycle strobe to paddles: centre and arm
//  o_Paddle_Start  out  1  one-cycle strobe to paddles: enable movement
//  o_Paddle_Reset  out  1  one-cycle strobe to paddles: freeze and recentre
//  o_Ball_Launch   out  1  one-cycle strobe to ball: serve
//  o_Serve_Dir     out  1  0 = serve toward P1, 1 = serve toward P2; valid with o_Ball_Launch
//  o_Score_P1      out  4  P1 score
//  o_Score_P2      out  4  P2 score
//  o_Winner        out  2  00 none, 01 P1, 10 P2
//  o_State         out  3  current FSM state encoding (debug/scoreboard)
// BEHAVIOUR
//  Reset (i_Reset_n=0 at a clock edge):
//   - state=IDLE; scores=0; o_Winner=00; o_Serve_Dir=1; frame counter=0; all strobes=0.
//   - The start-edge history register resets to 1, so a button held through reset does not start a game.
//  States: IDLE=0, READY=1, SERVE=2, PLAY=3, POINT=4, GAME_OVER=5, PAUSE=6.
//  All outputs are registered. A strobe is high exactly in the first cycle after the transition that causes it.
//  IDLE: start edge -> READY. Scores are cleared on this transition.
//  READY:
//   - o_Paddle_Ready strobes on entry; frame counter clears on entry.
//   - Counter increments on each i_Frame_Tick. When the tick brings the count to SERVE_FRAMES -> SERVE.
//  SERVE: single-cycle state -> PLAY. o_Paddle_Start and o_Ball_Launch strobe together on entry to PLAY.
//  PLAY:
//   - i_Miss_P1 alone: Score_P2+1, Serve_Dir=0.
//   - i_Miss_P2 alone: Score_P1+1, Serve_Dir=1.
//   - Both in the same cycle: no score, Serve_Dir unchanged, -> POINT.
//   - If the incremented score == WIN_SCORE -> GAME_OVER and set o_Winner; otherwise -> POINT.
//   - Misses outside PLAY are ignored. Scores saturate at WIN_SCORE and never wrap.
//  POINT: o_Paddle_Reset strobes on entry; counter clears. After POINT_FRAMES ticks -> READY.
//  GAME_OVER:
//   - o_Paddle_Reset strobes on entry; scores and o_Winner hold.
//   - Start edge -> READY, clearing scores and o_Winner.
//  In IDLE and GAME_OVER the start edge is the only exit. In READY, SERVE and POINT start edges are ignored.
//  A frame tick coinciding with a state entry is not counted. The counter only advances in the state after entry.
//  Reset asserted mid-round overrides everything; no strobes are emitted in the reset cycle.
//  Frame counter width = $clog2(max(SERVE_FRAMES,POINT_FRAMES)+1).
// CONFIGURATION
//  PONG_PAUSE_EN defined:
//   - Start edge in PLAY -> PAUSE. While paused, misses are ignored and nothing strobes.
//   - Start edge in PAUSE -> PLAY and strobes o_Paddle_Start only (no launch).
//  PONG_PAUSE_EN undefined:
//   - Start edge in PLAY is ignored. PAUSE (6) is unreachable; o_State never shows 6.
// TESTING (bench overrides WIN_SCORE=2, SERVE_FRAMES=2, POINT_FRAMES=1)
//  1 Hold i_Start=1 through reset release, then keep it high
//     -> stays IDLE; first 0->1 edge -> READY + one-cycle o_Paddle_Ready.
//  2 From READY, send 2 frame ticks
//     -> SERVE then PLAY; o_Paddle_Start=o_Ball_Launch=1 for one cycle, o_Serve_Dir=1.
//  3 In PLAY pulse i_Miss_P1
//     -> Score_P2=1, Serve_Dir=0, POINT with o_Paddle_Reset strobe; 1 tick -> READY.
//  4 Drive i_Miss_P1 and i_Miss_P2 in the same cycle during PLAY
//     -> scores unchanged, Serve_Dir unchanged, POINT.
//  5 P1 scores twice -> GAME_OVER, o_Winner=01, Score_P1=2.
//     Further misses and ticks: no change. Start edge -> READY, scores=0, o_Winner=00.
//  6 Assert i_Reset_n=0 during POINT -> next cycle IDLE, scores=0, strobes low.
//     With PONG_PAUSE_EN: start edge in PLAY -> o_State=6; a miss while paused is ignored.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
// Top-level Pong round sequencer. Owns both scores, the serve direction and the
// round state machine, and issues one-cycle strobes to the paddle controllers
// and the ball block.
//
// Optional feature macro: PONG_PAUSE_EN (start edge in PLAY pauses the game).
//
// Ports:
//   i_Clk           system/pixel clock
//   i_Reset_n       synchronous reset, active-low
//   i_Start         synchronised start button level (rising edge detected here)
//   i_Frame_Tick    one-cycle pulse per video frame
//   i_Miss_P1       one-cycle pulse: ball passed the left paddle
//   i_Miss_P2       one-cycle pulse: ball passed the right paddle
//   o_Paddle_Ready  strobe: centre and arm paddles
//   o_Paddle_Start  strobe: enable paddle movement
//   o_Paddle_Reset  strobe: freeze and recentre paddles
//   o_Ball_Launch   strobe: serve the ball
//   o_Serve_Dir     0 = serve toward P1, 1 = toward P2
//   o_Score_P1/P2   4-bit scores
//   o_Winner        00 none, 01 P1, 10 P2
//   o_State         current state encoding
// -----------------------------------------------------------------------------
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic       i_Start,
    input  logic       i_Frame_Tick,
    input  logic       i_Miss_P1,
    input  logic       i_Miss_P2,
    output logic       o_Paddle_Ready,
    output logic       o_Paddle_Start,
    output logic       o_Paddle_Reset,
    output logic       o_Ball_Launch,
    output logic       o_Serve_Dir,
    output logic [3:0] o_Score_P1,
    output logic [3:0] o_Score_P2,
    output logic [1:0] o_Winner,
    output logic [2:0] o_State
);

    localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READY     = 3'd1,
        S_SERVE     = 3'd2,
        S_PLAY      = 3'd3,
        S_POINT     = 3'd4,
        S_GAME_OVER = 3'd5,
        S_PAUSE     = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         score_p1_q, score_p1_d;
    logic [3:0]         score_p2_q, score_p2_d;
    logic [1:0]         winner_q, winner_d;
    logic               serve_dir_q, serve_dir_d;
    logic               start_prev_q;
    logic               ready_q, ready_d;
    logic               pstart_q, pstart_d;
    logic               preset_q, preset_d;
    logic               launch_q, launch_d;

    logic               start_edge_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic [4:0]         p1_inc_s;
    logic [4:0]         p2_inc_s;

    assign start_edge_s = i_Start & ~start_prev_q;
    assign cnt_inc_s    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    // One extra bit so the saturation compare can never see a wrapped value.
    assign p1_inc_s     = {1'b0, score_p1_q} + 5'd1;
    assign p2_inc_s     = {1'b0, score_p2_q} + 5'd1;

    // Next-state, score bookkeeping and strobe generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        ready_d     = 1'b0;
        pstart_d    = 1'b0;
        preset_d    = 1'b0;
        launch_d    = 1'b0;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_edge_s) begin
                    state_d    = S_READY;
                    cnt_d      = '0;
                    score_p1_d = 4'd0;
                    score_p2_d = 4'd0;
                    winner_d   = 2'b00;
                    ready_d    = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_READY: begin
                if (i_Frame_Tick) begin
                    if (cnt_inc_s == CNT_W'(SERVE_FRAMES)) begin
                        state_d = S_SERVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_SERVE: begin
                state_d  = S_PLAY;
                pstart_d = 1'b1;
                launch_d = 1'b1;
            end
            S_PLAY: begin
                if (i_Miss_P1 && i_Miss_P2) begin
                    // Simultaneous misses: replay the point, nobody scores.
                    state_d  = S_POINT;
                    cnt_d    = '0;
                    preset_d = 1'b1;
                end else if (i_Miss_P1) begin
                    serve_dir_d = 1'b0;
                    preset_d    = 1'b1;
                    cnt_d       = '0;
                    if (p2_inc_s >= 5'(WIN_SCORE)) begin
                        score_p2_d = 4'(WIN_SCORE);
                        winner_d   = 2'b10;
                        state_d    = S_GAME_OVER;
                    end else begin
                        score_p2_d = p2_inc_s[3:0];
                        state_d    = S_POINT;
                    end
                end else if (i_Miss_P2) begin
                    serve_dir_d = 1'b1;
                    preset_d    = 1'b1;
                    cnt_d       = '0;
                    if (p1_inc_s >= 5'(WIN_SCORE)) begin
                        score_p1_d = 4'(WIN_SCORE);
                        winner_d   = 2'b01;
                        state_d    = S_GAME_OVER;
                    end else begin
                        score_p1_d = p1_inc_s[3:0];
                        state_d    = S_POINT;
                    end
                end else begin
`ifdef PONG_PAUSE_EN
                    if (start_edge_s) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_PLAY;
                    end
`else
                    state_d = S_PLAY;
`endif
                end
            end
            S_PAUSE: begin
`ifdef PONG_PAUSE_EN
                if (start_edge_s) begin
                    state_d  = S_PLAY;
                    pstart_d = 1'b1;
                end else begin
                    state_d = S_PAUSE;
                end
`else
                // Unreachable without the pause feature; recover to IDLE.
                state_d = S_IDLE;
`endif
            end
            S_POINT: begin
                if (i_Frame_Tick) begin
                    if (cnt_inc_s == CNT_W'(POINT_FRAMES)) begin
                        state_d = S_READY;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, score and registered-output update with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            score_p1_q   <= 4'd0;
            score_p2_q   <= 4'd0;
            winner_q     <= 2'b00;
            serve_dir_q  <= 1'b1;
            // A button held through reset must not look like a fresh press.
            start_prev_q <= 1'b1;
            ready_q      <= 1'b0;
            pstart_q     <= 1'b0;
            preset_q     <= 1'b0;
            launch_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_p1_q   <= score_p1_d;
            score_p2_q   <= score_p2_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            start_prev_q <= i_Start;
            ready_q      <= ready_d;
            pstart_q     <= pstart_d;
            preset_q     <= preset_d;
            launch_q     <= launch_d;
        end
    end

    assign o_Paddle_Ready = ready_q;
    assign o_Paddle_Start = pstart_q;
    assign o_Paddle_Reset = preset_q;
    assign o_Ball_Launch  = launch_q;
    assign o_Serve_Dir    = serve_dir_q;
    assign o_Score_P1     = score_p1_q;
    assign o_Score_P2     = score_p2_q;
    assign o_Winner       = winner_q;
    assign o_State        = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_game_ctrl
// Directed bench for pong_game_ctrl with WIN_SCORE=2, SERVE_FRAMES=2,
// POINT_FRAMES=1. Strobes are checked as a 4-bit vector
// {Paddle_Ready, Paddle_Start, Paddle_Reset, Ball_Launch}.
// -----------------------------------------------------------------------------
module tb_pong_game_ctrl;

    logic       clk_s = 1'b0;
    logic       rst_n_s;
    logic       start_s;
    logic       frame_s;
    logic       miss1_s;
    logic       miss2_s;
    logic       ready_s, pstart_s, preset_s, launch_s, dir_s;
    logic [3:0] p1_s, p2_s;
    logic [1:0] win_s;
    logic [2:0] state_s;
    logic [3:0] strb_s;

    int checks = 0;
    int errors = 0;

    pong_game_ctrl #(
        .WIN_SCORE   (2),
        .SERVE_FRAMES(2),
        .POINT_FRAMES(1)
    ) dut (
        .i_Clk         (clk_s),
        .i_Reset_n     (rst_n_s),
        .i_Start       (start_s),
        .i_Frame_Tick  (frame_s),
        .i_Miss_P1     (miss1_s),
        .i_Miss_P2     (miss2_s),
        .o_Paddle_Ready(ready_s),
        .o_Paddle_Start(pstart_s),
        .o_Paddle_Reset(preset_s),
        .o_Ball_Launch (launch_s),
        .o_Serve_Dir   (dir_s),
        .o_Score_P1    (p1_s),
        .o_Score_P2    (p2_s),
        .o_Winner      (win_s),
        .o_State       (state_s)
    );

    assign strb_s = {ready_s, pstart_s, preset_s, launch_s};

    always #5 clk_s = ~clk_s;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then stable for checking.
    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic pulse_frame();
        frame_s = 1'b1;
        step();
        frame_s = 1'b0;
    endtask

    task automatic start_edge();
        start_s = 1'b0;
        step();
        start_s = 1'b1;
        step();
    endtask

    // READY -> SERVE -> PLAY (two frame ticks, SERVE lasts one cycle).
    task automatic go_play();
        pulse_frame();
        step();
        pulse_frame();
        step();
    endtask

    initial begin
        rst_n_s = 1'b0;
        start_s = 1'b1;
        frame_s = 1'b0;
        miss1_s = 1'b0;
        miss2_s = 1'b0;
        step();
        step();
        check_eq("rst_state", int'(state_s), 0);
        check_eq("rst_p1", int'(p1_s), 0);
        check_eq("rst_p2", int'(p2_s), 0);
        check_eq("rst_win", int'(win_s), 0);
        check_eq("rst_dir", int'(dir_s), 1);
        check_eq("rst_strb", int'(strb_s), 0);

        // 1: start held through reset release does not start a game
        rst_n_s = 1'b1;
        step();
        step();
        step();
        check_eq("t1_hold_idle", int'(state_s), 0);
        start_edge();
        check_eq("t1_ready", int'(state_s), 1);
        check_eq("t1_ready_strb", int'(strb_s), int'(4'b1000));
        step();
        check_eq("t1_strb_once", int'(strb_s), 0);

        // 2: two ticks -> SERVE -> PLAY with start+launch
        pulse_frame();
        check_eq("t2_one_tick", int'(state_s), 1);
        step();
        pulse_frame();
        check_eq("t2_serve", int'(state_s), 2);
        step();
        check_eq("t2_play", int'(state_s), 3);
        check_eq("t2_launch_strb", int'(strb_s), int'(4'b0101));
        check_eq("t2_dir", int'(dir_s), 1);
        step();
        check_eq("t2_strb_once", int'(strb_s), 0);

`ifdef PONG_PAUSE_EN
        start_edge();
        check_eq("pause_state", int'(state_s), 6);
        miss1_s = 1'b1;
        step();
        miss1_s = 1'b0;
        check_eq("pause_miss_ign", int'(p2_s), 0);
        check_eq("pause_hold", int'(state_s), 6);
        start_edge();
        check_eq("resume_state", int'(state_s), 3);
        check_eq("resume_strb", int'(strb_s), int'(4'b0100));
`else
        start_edge();
        check_eq("play_start_ign", int'(state_s), 3);
        check_eq("play_start_strb", int'(strb_s), 0);
`endif

        // 3: P1 misses -> P2 scores, serve toward P1
        miss1_s = 1'b1;
        step();
        miss1_s = 1'b0;
        check_eq("t3_point", int'(state_s), 4);
        check_eq("t3_p2", int'(p2_s), 1);
        check_eq("t3_dir", int'(dir_s), 0);
        check_eq("t3_reset_strb", int'(strb_s), int'(4'b0010));
        step();
        check_eq("t3_strb_once", int'(strb_s), 0);
        pulse_frame();
        check_eq("t3_back_ready", int'(state_s), 1);
        check_eq("t3_ready_strb", int'(strb_s), int'(4'b1000));
        go_play();
        check_eq("t3_play", int'(state_s), 3);
        check_eq("t3_launch_dir", int'(dir_s), 0);

        // 4: simultaneous misses -> no score, direction unchanged
        miss1_s = 1'b1;
        miss2_s = 1'b1;
        step();
        miss1_s = 1'b0;
        miss2_s = 1'b0;
        check_eq("t4_point", int'(state_s), 4);
        check_eq("t4_p1", int'(p1_s), 0);
        check_eq("t4_p2", int'(p2_s), 1);
        check_eq("t4_dir", int'(dir_s), 0);
        pulse_frame();
        go_play();

        // 5: P1 scores twice -> GAME_OVER
        miss2_s = 1'b1;
        step();
        miss2_s = 1'b0;
        check_eq("t5_p1_one", int'(p1_s), 1);
        check_eq("t5_dir", int'(dir_s), 1);
        check_eq("t5_point", int'(state_s), 4);
        pulse_frame();
        go_play();
        check_eq("t5_launch", int'(strb_s), int'(4'b0101));
        miss2_s = 1'b1;
        step();
        miss2_s = 1'b0;
        check_eq("t5_over", int'(state_s), 5);
        check_eq("t5_winner", int'(win_s), 1);
        check_eq("t5_p1_two", int'(p1_s), 2);
        check_eq("t5_over_strb", int'(strb_s), int'(4'b0010));
        miss1_s = 1'b1;
        frame_s = 1'b1;
        step();
        miss1_s = 1'b0;
        frame_s = 1'b0;
        step();
        check_eq("t5_hold_state", int'(state_s), 5);
        check_eq("t5_hold_p1", int'(p1_s), 2);
        check_eq("t5_hold_p2", int'(p2_s), 1);
        check_eq("t5_hold_win", int'(win_s), 1);
        check_eq("t5_hold_strb", int'(strb_s), 0);
        start_edge();
        check_eq("t5_restart", int'(state_s), 1);
        check_eq("t5_clr_p1", int'(p1_s), 0);
        check_eq("t5_clr_p2", int'(p2_s), 0);
        check_eq("t5_clr_win", int'(win_s), 0);
        check_eq("t5_ready_strb", int'(strb_s), int'(4'b1000));

        // 6: reset during POINT overrides a pending exit
        go_play();
        miss1_s = 1'b1;
        step();
        miss1_s = 1'b0;
        check_eq("t6_point", int'(state_s), 4);
        rst_n_s = 1'b0;
        frame_s = 1'b1;
        step();
        check_eq("t6_idle", int'(state_s), 0);
        check_eq("t6_p2", int'(p2_s), 0);
        check_eq("t6_strb", int'(strb_s), 0);
        check_eq("t6_dir", int'(dir_s), 1);
        frame_s = 1'b0;
        rst_n_s = 1'b1;
        step();
        check_eq("t6_stay_idle", int'(state_s), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
